// File: rtl/sata_oob_defs.sv
// Shared definitions for the SATA host OOB sequencer: state encoding,
// primitive dwords and their K masks.
package sata_oob_defs;

    typedef enum logic [3:0] {
        ST_IDLE           = 4'd0,
        ST_SEND_INIT      = 4'd1,
        ST_WAIT_INIT_DONE = 4'd2,
        ST_WAIT_INIT      = 4'd3,
        ST_SEND_WAKE      = 4'd4,
        ST_WAIT_WAKE_DONE = 4'd5,
        ST_WAIT_WAKE      = 4'd6,
        ST_WAIT_NOIDLE    = 4'd7,
        ST_SEND_D10       = 4'd8,
        ST_SEND_ALIGN     = 4'd9,
        ST_LINK_UP        = 4'd10,
        ST_RETRY          = 4'd11,
        ST_ERROR          = 4'd12
    } oob_state_e;

    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K  = 4'b0001;
    localparam logic [31:0] D102_DW  = 32'h4A4A4A4A;
    localparam logic [3:0]  D102_K   = 4'b0000;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;
    localparam logic [3:0]  SYNC_K   = 4'b0001;

    // TX driver is held idle everywhere except the D10.2/ALIGN/link phases.
    function automatic logic tx_idle_state(input oob_state_e s);
        case (s)
            ST_SEND_D10, ST_SEND_ALIGN, ST_LINK_UP: tx_idle_state = 1'b0;
            default:                                tx_idle_state = 1'b1;
        endcase
    endfunction

    function automatic logic wait_state(input oob_state_e s);
        case (s)
            ST_WAIT_INIT_DONE, ST_WAIT_INIT, ST_WAIT_WAKE_DONE, ST_WAIT_WAKE,
            ST_WAIT_NOIDLE, ST_SEND_D10, ST_SEND_ALIGN: wait_state = 1'b1;
            default:                                    wait_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/oob_timeout_cnt.sv
// Per-state wait timer: cleared on state entry, counts while enabled,
// flags expiry on the last allowed cycle.
module oob_timeout_cnt #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd880000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 20'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == TIMEOUT_CYCLES - 20'd1);

endmodule

// File: rtl/sata_host_oob_ctrl.sv
// Host-side SATA OOB sequencer (TXUSRCLK2 domain): COMRESET, COMWAKE,
// D10.2 and ALIGN handshake, with timeouts, retries and device re-wake.
module sata_host_oob_ctrl
    import sata_oob_defs::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES   = 20'd880000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned NONALIGN_CNT     = 3,
    parameter int unsigned IDLE_LOSS_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        oob_start,
    output logic        txcominit,
    output logic        txcomwake,
    input  logic        txcomfinish,
    output logic        txelecidle,
    output logic [31:0] txdata,
    output logic [3:0]  txcharisk,
    input  logic        rxcominitdet,
    input  logic        rxcomwakedet,
    input  logic        rxelecidle,
    input  logic        rxbyteisaligned,
    input  logic [31:0] rxdata,
    input  logic [3:0]  rxcharisk,
    output logic        link_up,
    output logic        oob_error,
    output logic [3:0]  oob_state
);

    localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);
    localparam logic [7:0] NONALIGN_W  = 8'(NONALIGN_CNT);
    localparam logic [7:0] IDLE_LOSS_W = 8'(IDLE_LOSS_CYCLES);

    oob_state_e  state_q, state_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  nalign_q, nalign_d;
    logic [7:0]  idle_q, idle_d;
    logic        cominit_seen_q, cominit_seen_d;
    logic        txcominit_q, txcominit_d;
    logic        txcomwake_q, txcomwake_d;
    logic        txelecidle_q, txelecidle_d;
    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  txcharisk_q, txcharisk_d;
    logic        link_up_q, link_up_d;
    logic        oob_error_q, oob_error_d;
    logic        timeout;
    logic        rx_is_align;

    assign rx_is_align = (rxdata == ALIGN_DW) && (rxcharisk == ALIGN_K);

    oob_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_d != state_q),
        .en      (wait_state(state_q)),
        .expired (timeout)
    );

    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        nalign_d       = '0;
        idle_d         = '0;
        cominit_seen_d = 1'b0;
        if (oob_start) begin
            state_d = ST_SEND_INIT;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SEND_INIT: state_d = ST_WAIT_INIT_DONE;
                ST_WAIT_INIT_DONE: begin
                    // A device COMINIT can beat our own burst completion.
                    cominit_seen_d = cominit_seen_q | rxcominitdet;
                    if (txcomfinish)  state_d = ST_WAIT_INIT;
                    else if (timeout) state_d = ST_RETRY;
                end
                ST_WAIT_INIT: begin
                    cominit_seen_d = cominit_seen_q;
                    if (rxcominitdet || cominit_seen_q) state_d = ST_SEND_WAKE;
                    else if (timeout)                   state_d = ST_RETRY;
                end
                ST_SEND_WAKE: state_d = ST_WAIT_WAKE_DONE;
                ST_WAIT_WAKE_DONE: begin
                    if (txcomfinish)  state_d = ST_WAIT_WAKE;
                    else if (timeout) state_d = ST_RETRY;
                end
                ST_WAIT_WAKE: begin
                    if (rxcomwakedet) state_d = ST_WAIT_NOIDLE;
                    else if (timeout) state_d = ST_RETRY;
                end
                ST_WAIT_NOIDLE: begin
                    if (!rxelecidle)  state_d = ST_SEND_D10;
                    else if (timeout) state_d = ST_RETRY;
                end
                ST_SEND_D10: begin
                    if (rx_is_align && rxbyteisaligned) state_d = ST_SEND_ALIGN;
                    else if (timeout)                   state_d = ST_RETRY;
                end
                ST_SEND_ALIGN: begin
                    if (rxbyteisaligned && !rx_is_align) nalign_d = nalign_q + 8'd1;
                    if (nalign_d == NONALIGN_W) state_d = ST_LINK_UP;
                    else if (timeout)           state_d = ST_RETRY;
                end
                ST_LINK_UP: begin
                    if (rxcominitdet) begin
                        state_d = ST_SEND_WAKE;
                    end else begin
                        if (rxelecidle) idle_d = idle_q + 8'd1;
                        if (idle_d == IDLE_LOSS_W) begin
                            state_d = ST_SEND_INIT;
                            retry_d = '0;
                        end
                    end
                end
                ST_RETRY: begin
                    retry_d = retry_q + 8'd1;
                    if (MAX_RETRY != 0 && retry_d == MAX_RETRY_W) state_d = ST_ERROR;
                    else                                          state_d = ST_SEND_INIT;
                end
                ST_ERROR: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        txcominit_d  = (state_d == ST_SEND_INIT);
        txcomwake_d  = (state_d == ST_SEND_WAKE);
        txelecidle_d = tx_idle_state(state_d);
        link_up_d    = (state_d == ST_LINK_UP);
        oob_error_d  = (state_d == ST_ERROR);
        txdata_d     = '0;
        txcharisk_d  = '0;
        case (state_d)
            ST_SEND_D10: begin
                txdata_d    = D102_DW;
                txcharisk_d = D102_K;
            end
            ST_SEND_ALIGN, ST_LINK_UP: begin
                txdata_d    = ALIGN_DW;
                txcharisk_d = ALIGN_K;
            end
            default: ;
        endcase
    end

    // reset_n deassertion is expected to arrive synchronised to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            retry_q        <= '0;
            nalign_q       <= '0;
            idle_q         <= '0;
            cominit_seen_q <= 1'b0;
            txcominit_q    <= 1'b0;
            txcomwake_q    <= 1'b0;
            txelecidle_q   <= 1'b1;
            txdata_q       <= '0;
            txcharisk_q    <= '0;
            link_up_q      <= 1'b0;
            oob_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            nalign_q       <= nalign_d;
            idle_q         <= idle_d;
            cominit_seen_q <= cominit_seen_d;
            txcominit_q    <= txcominit_d;
            txcomwake_q    <= txcomwake_d;
            txelecidle_q   <= txelecidle_d;
            txdata_q       <= txdata_d;
            txcharisk_q    <= txcharisk_d;
            link_up_q      <= link_up_d;
            oob_error_q    <= oob_error_d;
        end
    end

    assign txcominit  = txcominit_q;
    assign txcomwake  = txcomwake_q;
    assign txelecidle = txelecidle_q;
    assign txdata     = txdata_q;
    assign txcharisk  = txcharisk_q;
    assign link_up    = link_up_q;
    assign oob_error  = oob_error_q;
    assign oob_state  = state_q;

endmodule

// File: tb/tb_sata_host_oob_ctrl.sv
// Directed bench for sata_host_oob_ctrl: table of per-cycle vectors for the
// bring-up path, plus hand sequences for line loss, retries and async reset.
module tb_sata_host_oob_ctrl;

    localparam logic [1:0] RX_NONE = 2'd0, RX_ALIGN = 2'd1, RX_SYNC = 2'd2;
    localparam logic [1:0] TX_Z = 2'd0, TX_D10 = 2'd1, TX_AL = 2'd2;

    logic        clk, reset_n, oob_start, txcomfinish;
    logic        txcominit, txcomwake, txelecidle;
    logic [31:0] txdata, rxdata;
    logic [3:0]  txcharisk, rxcharisk, oob_state;
    logic        rxcominitdet, rxcomwakedet, rxelecidle, rxbyteisaligned;
    logic        link_up, oob_error;
    logic [4:0]  flags;

    assign flags = {link_up, oob_error, txelecidle, txcominit, txcomwake};

    sata_host_oob_ctrl #(
        .TIMEOUT_CYCLES(20'd50), .MAX_RETRY(3), .NONALIGN_CNT(3), .IDLE_LOSS_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .oob_start(oob_start),
        .txcominit(txcominit), .txcomwake(txcomwake), .txcomfinish(txcomfinish),
        .txelecidle(txelecidle), .txdata(txdata), .txcharisk(txcharisk),
        .rxcominitdet(rxcominitdet), .rxcomwakedet(rxcomwakedet),
        .rxelecidle(rxelecidle), .rxbyteisaligned(rxbyteisaligned),
        .rxdata(rxdata), .rxcharisk(rxcharisk),
        .link_up(link_up), .oob_error(oob_error), .oob_state(oob_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in: {oob_start, txcomfinish, rxcominitdet, rxcomwakedet, rxelecidle, rxbyteisaligned}
    // fl: {link_up, oob_error, txelecidle, txcominit, txcomwake}
    typedef struct {
        logic [5:0] in;
        logic [1:0] rx;
        logic [3:0] st;
        logic [4:0] fl;
        logic [1:0] tx;
    } vec_t;

    vec_t vt[29];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] tx_exp(input logic [1:0] sel);
        case (sel)
            TX_D10:  tx_exp = {32'h4A4A4A4A, 4'b0000};
            TX_AL:   tx_exp = {32'h7B4A4ABC, 4'b0001};
            default: tx_exp = 36'h0;
        endcase
    endfunction

    task automatic set_in(input logic [5:0] in, input logic [1:0] rx);
        {oob_start, txcomfinish, rxcominitdet, rxcomwakedet, rxelecidle, rxbyteisaligned} = in;
        case (rx)
            RX_ALIGN: begin rxdata = 32'h7B4A4ABC; rxcharisk = 4'b0001; end
            RX_SYNC:  begin rxdata = 32'hB5B5957C; rxcharisk = 4'b0001; end
            default:  begin rxdata = 32'h0;        rxcharisk = 4'b0000; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] st, input logic [4:0] fl,
                           input logic [1:0] tx);
        chk({tag, " state"}, 36'(oob_state), 36'(st));
        chk({tag, " flags"}, 36'(flags), 36'(fl));
        chk({tag, " txdata"}, {txdata, txcharisk}, tx_exp(tx));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc;
        int pulses;
        vt = '{
            '{6'b100010, RX_NONE,  4'd1,  5'b00110, TX_Z},   // oob_start -> COMINIT pulse
            '{6'b000010, RX_NONE,  4'd2,  5'b00100, TX_Z},
            '{6'b001010, RX_NONE,  4'd2,  5'b00100, TX_Z},   // early COMINIT, latched
            '{6'b010010, RX_NONE,  4'd3,  5'b00100, TX_Z},
            '{6'b000010, RX_NONE,  4'd4,  5'b00101, TX_Z},   // latched COMINIT -> COMWAKE
            '{6'b000010, RX_NONE,  4'd5,  5'b00100, TX_Z},
            '{6'b010010, RX_NONE,  4'd6,  5'b00100, TX_Z},
            '{6'b000110, RX_NONE,  4'd7,  5'b00100, TX_Z},
            '{6'b000010, RX_NONE,  4'd7,  5'b00100, TX_Z},
            '{6'b000000, RX_NONE,  4'd8,  5'b00000, TX_D10},
            '{6'b000000, RX_ALIGN, 4'd8,  5'b00000, TX_D10}, // ALIGN but not byte-aligned
            '{6'b000001, RX_ALIGN, 4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_ALIGN, 4'd9,  5'b00000, TX_AL},  // glitch resets count
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000000, RX_SYNC,  4'd9,  5'b00000, TX_AL},  // unaligned resets count
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd10, 5'b10000, TX_AL},  // third SYNC -> link up
            '{6'b001001, RX_SYNC,  4'd4,  5'b00101, TX_Z},   // device COMINIT -> re-wake
            '{6'b000001, RX_NONE,  4'd5,  5'b00100, TX_Z},
            '{6'b010001, RX_NONE,  4'd6,  5'b00100, TX_Z},
            '{6'b000101, RX_NONE,  4'd7,  5'b00100, TX_Z},
            '{6'b000001, RX_NONE,  4'd8,  5'b00000, TX_D10},
            '{6'b000001, RX_ALIGN, 4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd9,  5'b00000, TX_AL},
            '{6'b000001, RX_SYNC,  4'd10, 5'b10000, TX_AL}
        };

        reset_n = 1'b0;
        set_in(6'b000010, RX_NONE);
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'd0, 5'b00100, TX_Z);
        reset_n = 1'b1;
        step();
        chk_out("idle", 4'd0, 5'b00100, TX_Z);

        for (int i = 0; i < 29; i++) begin
            set_in(vt[i].in, vt[i].rx);
            step();
            chk_out($sformatf("vec%0d", i), vt[i].st, vt[i].fl, vt[i].tx);
        end

        // Line loss: 15 idle cycles tolerated, 16 consecutive drop the link.
        set_in(6'b000011, RX_SYNC);
        for (int i = 0; i < 15; i++) step();
        chk_out("idle15", 4'd10, 5'b10000, TX_AL);
        set_in(6'b000001, RX_SYNC);
        step();
        chk_out("idle_break", 4'd10, 5'b10000, TX_AL);
        set_in(6'b000011, RX_SYNC);
        for (int i = 0; i < 15; i++) step();
        chk_out("idle15b", 4'd10, 5'b10000, TX_AL);
        step();
        chk_out("idle16", 4'd1, 5'b00110, TX_Z);

        // No device: each attempt is SEND_INIT + 50 wait cycles + RETRY.
        set_in(6'b000010, RX_NONE);
        cyc = 0;
        pulses = 1;
        while (oob_error !== 1'b1 && cyc < 1000) begin
            step();
            cyc++;
            if (txcominit === 1'b1) pulses++;
        end
        chk("err_cycles", 36'(cyc), 36'd156);
        chk("cominit_pulses", 36'(pulses), 36'd3);
        chk_out("error", 4'd12, 5'b01100, TX_Z);

        set_in(6'b100010, RX_NONE);
        step();
        chk_out("restart", 4'd1, 5'b00110, TX_Z);
        set_in(6'b000010, RX_NONE);
        step();
        chk_out("restart_wait", 4'd2, 5'b00100, TX_Z);
        set_in(6'b110010, RX_NONE);
        step();
        chk_out("start_prio", 4'd1, 5'b00110, TX_Z);

        set_in(6'b000010, RX_NONE); step();
        set_in(6'b010010, RX_NONE); step();
        set_in(6'b001010, RX_NONE); step();
        set_in(6'b000010, RX_NONE); step();
        set_in(6'b010010, RX_NONE); step();
        set_in(6'b000110, RX_NONE); step();
        set_in(6'b000000, RX_NONE); step();
        chk_out("d10", 4'd8, 5'b00000, TX_D10);

        // Async reset between clock edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 4'd0, 5'b00100, TX_Z);
        set_in(6'b000010, RX_NONE);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_out("post_rst", 4'd0, 5'b00100, TX_Z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sata_host_oob_ctrl.md
Name: sata_host_oob_ctrl

Overview:
Host-side SATA out-of-band sequencer that sits directly on the fabric side of the GTX channel model, in the TXUSRCLK2 domain. It drives TXCOMINIT/TXCOMWAKE/TXELECIDLE and the 32-bit TX data/K path, and consumes RXCOMINITDET/RXCOMWAKEDET/RXELECIDLE/RXBYTEISALIGNED and the RX data/K path. It runs COMRESET -> COMWAKE -> D10.2 -> ALIGN handshake -> link up, with timeouts, bounded retries and device-initiated re-wake.

Parameters:
TIMEOUT_CYCLES, 20'd880000, wait budget per wait state in clk cycles; counter width 20 bits.
MAX_RETRY, 3, COMRESET attempts before ERROR; 0 means retry forever.
NONALIGN_CNT, 3, consecutive non-ALIGN, aligned RX dwords required to declare link up.
IDLE_LOSS_CYCLES, 16, consecutive rxelecidle cycles in LINK_UP that count as link loss.

Ports:
clk  in  1  TXUSRCLK2-domain clock
reset_n  in  1  asynchronous active-low reset
oob_start  in  1  pulse: start or restart OOB from any state
txcominit  out  1  one-cycle COMINIT request to channel
txcomwake  out  1  one-cycle COMWAKE request to channel
txcomfinish  in  1  channel: burst sequence finished
txelecidle  out  1  TX driver idle
txdata  out  32  TX dword
txcharisk  out  4  TX K flags, bit0 = byte0
rxcominitdet  in  1  COMINIT detected
rxcomwakedet  in  1  COMWAKE detected
rxelecidle  in  1  RX line idle
rxbyteisaligned  in  1  comma aligner locked
rxdata  in  32  RX dword
rxcharisk  in  4  RX K flags
link_up  out  1  link established
oob_error  out  1  retries exhausted
oob_state  out  4  current state encoding (debug)

Behaviour:
- Reset (async assert, sync deassert): state IDLE; txcominit=0, txcomwake=0, txelecidle=1, txdata=0, txcharisk=0, link_up=0, oob_error=0, retry count 0, timer 0. All outputs registered.
- Constants: ALIGN = 32'h7B4A4ABC, K=4'b0001; D10.2 = 32'h4A4A4A4A, K=4'b0000. An RX dword "is ALIGN" iff rxdata==ALIGN and rxcharisk==4'b0001.
- Timer clears on every state entry and increments in wait states; expiry = timer reaches TIMEOUT_CYCLES-1.
- States and transitions:
  IDLE: txelecidle=1; oob_start -> SEND_INIT, retry count cleared.
  SEND_INIT: txcominit pulsed exactly 1 cycle on entry -> WAIT_INIT_DONE.
  WAIT_INIT_DONE: txcomfinish -> WAIT_INIT; timeout -> RETRY.
  WAIT_INIT: rxcominitdet -> SEND_WAKE; timeout -> RETRY.
  SEND_WAKE: txcomwake pulsed 1 cycle on entry -> WAIT_WAKE_DONE.
  WAIT_WAKE_DONE: txcomfinish -> WAIT_WAKE; timeout -> RETRY.
  WAIT_WAKE: rxcomwakedet -> WAIT_NOIDLE; timeout -> RETRY.
  WAIT_NOIDLE: !rxelecidle -> SEND_D10; timeout -> RETRY.
  SEND_D10: txelecidle=0, TX D10.2 every cycle; RX ALIGN with rxbyteisaligned -> SEND_ALIGN; timeout -> RETRY.
  SEND_ALIGN: TX ALIGN every cycle; counts consecutive aligned non-ALIGN RX dwords (an ALIGN or !rxbyteisaligned resets the count); count==NONALIGN_CNT -> LINK_UP; timeout -> RETRY.
  LINK_UP: link_up=1; TX ALIGN continues (upper layer muxes its own data outside this block); rxcominitdet -> SEND_WAKE with link_up=0; rxelecidle for IDLE_LOSS_CYCLES consecutive cycles -> SEND_INIT with link_up=0 and retry count cleared.
  RETRY: retry count +1; if MAX_RETRY!=0 and new count==MAX_RETRY -> ERROR, else -> SEND_INIT. Takes 1 cycle.
  ERROR: oob_error=1, txelecidle=1; only oob_start leaves (-> SEND_INIT, oob_error cleared).
- txelecidle=1 in IDLE, SEND_INIT through WAIT_NOIDLE, RETRY and ERROR; txdata/txcharisk=0 whenever txelecidle=1.
- oob_start is evaluated before all other conditions in every state.
- An rxcominitdet arriving in WAIT_INIT_DONE is latched and satisfies WAIT_INIT on entry.
- link_up deasserts on the same clock edge that leaves LINK_UP.

Decomposition:
- Shared package/header sata_oob_defs: state encoding (4-bit localparams), ALIGN/D10.2/SYNC dword constants and their K masks.
- One sub-module, oob_timeout_cnt (clear, enable, expiry compare on TIMEOUT_CYCLES), instantiated once.

Test Plan:
- Nominal bring-up (TIMEOUT_CYCLES=200): oob_start, model answers COMINIT after 20 cycles, COMWAKE after 20, then ALIGN, then SYNC x3 -> exactly one txcominit pulse and one txcomwake pulse; txdata=4A4A4A4A then 7B4A4ABC; link_up=1 on the 3rd SYNC +1 cycle.
- No device (MAX_RETRY=3, TIMEOUT_CYCLES=50): no rxcominitdet -> 3 txcominit pulses, oob_error=1, link_up=0, txelecidle=1; a later oob_start clears oob_error and pulses txcominit again.
- Alignment glitch: in SEND_ALIGN feed SYNC, SYNC, ALIGN, SYNC x3 -> link_up only after the final 3 SYNC.
- Device-initiated reset: in LINK_UP pulse rxcominitdet -> link_up falls next edge, one txcomwake pulse, relink after COMWAKE+ALIGN+SYNC x3.
- Line loss: in LINK_UP hold rxelecidle 15 cycles -> link_up stays 1; hold 16 -> link_up=0 and txcominit pulses.
- Async reset mid-SEND_D10: assert reset_n low without a clk edge -> all outputs take reset values immediately; state IDLE after release.
